// File: rtl/alu_wb_buffer.sv
// alu_wb_buffer: in-order FIFO between ALU and writeback, with overflow status tracking
//   clk, rst_n (async, active-low)
//   in_valid/in_ready, in_data, in_ovf, in_op : ALU result push side
//   out_valid/out_ready, out_data, out_ovf, out_op : head entry pop side
//   count : occupied entries; ovf_clr, ovf_sticky, ovf_cnt : overflow status
module alu_wb_buffer #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_ovf,
  input  logic [OP_W-1:0]          in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_ovf,
  output logic [OP_W-1:0]          out_op,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     ovf_clr,
  output logic                     ovf_sticky,
  output logic [7:0]               ovf_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_W + OP_W + 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count, w_count_nxt;
  logic          r_sticky, w_sticky_nxt;
  logic [7:0]    r_cnt, w_cnt_nxt;
  logic          w_push, w_pop, w_ovf_push;
  logic [EW-1:0] w_head;
  assign in_ready   = r_count < FULL;
  assign out_valid  = r_count != '0;
  assign w_push     = in_valid && in_ready;
  assign w_pop      = out_valid && out_ready;
  assign w_ovf_push = w_push && in_ovf;
  // Outputs come only from storage; masked to zero while empty so reset reads 0
  assign w_head = out_valid ? r_mem[r_rd] : '0;
  assign {out_data, out_ovf, out_op} = w_head;
  assign count      = r_count;
  assign ovf_sticky = r_sticky;
  assign ovf_cnt    = r_cnt;
  always_comb begin
    w_count_nxt  = (w_push && !w_pop) ? r_count + 1'b1 :
                   (!w_push && w_pop) ? r_count - 1'b1 : r_count;
    // A same-cycle overflowed push wins over clear
    w_sticky_nxt = ovf_clr ? w_ovf_push : (r_sticky || w_ovf_push);
    w_cnt_nxt    = ovf_clr ? {7'd0, w_ovf_push} :
                   (w_ovf_push && r_cnt != 8'hff) ? r_cnt + 8'd1 : r_cnt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_count  <= '0;
      r_sticky <= 1'b0;
      r_cnt    <= 8'd0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count  <= w_count_nxt;
      r_sticky <= w_sticky_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end
  // Storage is not reset; entries are only visible while counted as occupied
  always_ff @(posedge clk) begin
    if (w_push && rst_n) r_mem[r_wr] <= {in_data, in_ovf, in_op};
  end
endmodule
